// File: rtl/replica_pkg.sv
// Shared types for the replica datapath.
// Holds the move command, the distance-ROM data width, the signed tour-length delta type and the
// microcode term layout used by delta_distance. Also provides wrap_pos, the modulo +/-1 helper
// for tour positions.
package replica_pkg;

   localparam int unsigned city_num = 30;

   typedef logic [17:0]        distance_data_t;
   typedef logic signed [20:0] delta_data_t;

   typedef enum logic [1:0] {CmdTwo, CmdOr0, CmdOr1, CmdThr} opt_command_t;

   typedef struct packed {
      opt_command_t command;
      logic [6:0]   k;
      logic [6:0]   l;
   } opt_t;

   // Endpoint selectors; the encoding matches the order in which cities are fetched.
   typedef enum logic [2:0] {SelK, SelKm, SelKp, SelL, SelLp} distance_select_t;

   // OpZeroPls loads the accumulator with d, so the first term needs no separate clear.
   typedef enum logic [1:0] {OpZeroPls, OpPls, OpMns} distance_op_t;

   typedef struct packed {
      distance_select_t a, b;
      distance_op_t     op;
   } delta_term_t;

   // Step a tour position by one in either direction, modulo n.
   function automatic logic [6:0] wrap_pos(input logic [6:0] pos, input logic dec,
                                           input logic [6:0] n);
      logic [6:0] res;
      if (dec) res = (pos == 7'd0) ? n - 7'd1 : pos - 7'd1;
      else     res = (pos == n - 7'd1) ? 7'd0 : pos + 7'd1;
      return res;
   endfunction

endpackage

// File: rtl/delta_microcode.sv
// Combinational term ROM for delta_distance.
// Ports:
//   cmd  - move command of the request in progress
//   idx  - term index (0 = first term)
//   term - endpoint pair and accumulate operation for this term
//   last - high on the final term of the command
module delta_microcode
   import replica_pkg::*;
(
   input  opt_command_t cmd,
   input  logic [2:0]   idx,
   output delta_term_t  term,
   output logic         last
);

   always_comb begin
      term = '{a: SelK, b: SelK, op: OpZeroPls};
      last = 1'b1;
      unique case (cmd)
         CmdTwo: begin
            last = (idx == 3'd3);
            case (idx)
               3'd0:    term = '{a: SelK,  b: SelL,  op: OpZeroPls};
               3'd1:    term = '{a: SelKp, b: SelLp, op: OpPls};
               3'd2:    term = '{a: SelK,  b: SelKp, op: OpMns};
               3'd3:    term = '{a: SelL,  b: SelLp, op: OpMns};
               default: last = 1'b1;
            endcase
         end
         // Both or-opt directions move city K between L and LP; only legality differs.
         CmdOr0, CmdOr1: begin
            last = (idx == 3'd5);
            case (idx)
               3'd0:    term = '{a: SelKm, b: SelKp, op: OpZeroPls};
               3'd1:    term = '{a: SelL,  b: SelK,  op: OpPls};
               3'd2:    term = '{a: SelK,  b: SelLp, op: OpPls};
               3'd3:    term = '{a: SelKm, b: SelK,  op: OpMns};
               3'd4:    term = '{a: SelK,  b: SelKp, op: OpMns};
               3'd5:    term = '{a: SelL,  b: SelLp, op: OpMns};
               default: last = 1'b1;
            endcase
         end
         CmdThr: last = 1'b1;
         default: last = 1'b1;
      endcase
   end

endmodule

// File: rtl/delta_distance.sv
// Signed tour-length change for one proposed move on one replica.
// Fetches the five cities around K and L from the tour-order RAM, then walks the microcode
// terms through the distance ROM and accumulates them.
// Ports:
//   clk, reset          - clock, asynchronous active-high reset
//   opt_valid/opt_ready - move request handshake; opt sampled on acceptance only
//   opt                 - command, K, L
//   pos_addr/pos_data   - tour-order RAM read port (1-cycle latency)
//   dist_a/dist_b       - distance ROM city pair; dist_data returns one cycle later
//   delta_valid         - one-cycle result strobe
//   delta, opt_err      - result and invalid-request flag, held until the next result
module delta_distance
   import replica_pkg::*;
#(
   parameter int unsigned CITY_NUM = city_num
) (
   input  logic           clk,
   input  logic           reset,
   input  logic           opt_valid,
   output logic           opt_ready,
   input  opt_t           opt,
   output logic [6:0]     pos_addr,
   input  logic [6:0]     pos_data,
   output logic [6:0]     dist_a,
   output logic [6:0]     dist_b,
   input  distance_data_t dist_data,
   output logic           delta_valid,
   output delta_data_t    delta,
   output logic           opt_err
);

   localparam logic [6:0] CityNum = 7'(CITY_NUM);

   typedef enum logic [1:0] {StIdle, StFetch, StCalc, StDone} state_t;

   state_t       state_q, state_d;
   opt_t         opt_q;
   logic [2:0]   cnt_q;
   logic [2:0]   tidx_q;
   logic [6:0]   c_k_q, c_km_q, c_kp_q, c_l_q, c_lp_q;
   logic         pend_q, pend_last_q;
   distance_op_t pend_op_q;
   delta_data_t  acc_q, acc_d;
   delta_data_t  delta_q;
   logic         err_q;

   logic         req_legal, order_ok;
   logic [6:0]   km, kp, lp;
   logic         issue;
   delta_term_t  mc_term;
   logic         mc_last;
   delta_data_t  ext;

   function automatic logic [6:0] city_of(input distance_select_t s, input logic [6:0] ck,
                                          input logic [6:0] ckm, input logic [6:0] ckp,
                                          input logic [6:0] cl, input logic [6:0] clp);
      logic [6:0] c;
      case (s)
         SelK:    c = ck;
         SelKm:   c = ckm;
         SelKp:   c = ckp;
         SelL:    c = cl;
         SelLp:   c = clp;
         default: c = '0;
      endcase
      return c;
   endfunction

   delta_microcode u_microcode (
      .cmd  (opt_q.command),
      .idx  (tidx_q),
      .term (mc_term),
      .last (mc_last)
   );

   // Request legality, evaluated on the live opt bus while idle.
   always_comb begin
      order_ok = 1'b0;
      unique case (opt.command)
         CmdTwo, CmdOr0: order_ok = (opt.k < opt.l);
         CmdOr1:         order_ok = ({1'b0, opt.k} > ({1'b0, opt.l} + 8'd1));
         CmdThr:         order_ok = 1'b0;
         default:        order_ok = 1'b0;
      endcase
      req_legal = order_ok && (opt.k < CityNum) && (opt.l < CityNum);
   end

   assign km = wrap_pos(opt_q.k, 1'b1, CityNum);
   assign kp = wrap_pos(opt_q.k, 1'b0, CityNum);
   assign lp = wrap_pos(opt_q.l, 1'b0, CityNum);

   // Stop issuing once the last term is in flight; its data arrives next cycle.
   assign issue = (state_q == StCalc) && !(pend_q && pend_last_q);

   assign ext = $signed({3'b000, dist_data});

   always_comb begin
      acc_d = acc_q;
      case (pend_op_q)
         OpZeroPls: acc_d = ext;
         OpPls:     acc_d = acc_q + ext;
         OpMns:     acc_d = acc_q - ext;
         default:   acc_d = acc_q;
      endcase
   end

   // FSM state register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) state_q <= StIdle;
      else       state_q <= state_d;
   end

   // FSM next state
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle:  if (opt_valid) state_d = req_legal ? StFetch : StDone;
         StFetch: if (cnt_q == 3'd5) state_d = StCalc;
         StCalc:  if (pend_q && pend_last_q) state_d = StDone;
         StDone:  state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   // FSM outputs
   always_comb begin
      opt_ready   = (state_q == StIdle);
      delta_valid = (state_q == StDone);
      pos_addr    = '0;
      dist_a      = '0;
      dist_b      = '0;
      if (state_q == StFetch) begin
         case (cnt_q)
            3'd0:    pos_addr = opt_q.k;
            3'd1:    pos_addr = km;
            3'd2:    pos_addr = kp;
            3'd3:    pos_addr = opt_q.l;
            3'd4:    pos_addr = lp;
            default: pos_addr = '0;
         endcase
      end
      if (issue) begin
         dist_a = city_of(mc_term.a, c_k_q, c_km_q, c_kp_q, c_l_q, c_lp_q);
         dist_b = city_of(mc_term.b, c_k_q, c_km_q, c_kp_q, c_l_q, c_lp_q);
      end
   end

   assign delta   = delta_q;
   assign opt_err = err_q;

   // Datapath
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         opt_q       <= '0;
         cnt_q       <= '0;
         tidx_q      <= '0;
         c_k_q       <= '0;
         c_km_q      <= '0;
         c_kp_q      <= '0;
         c_l_q       <= '0;
         c_lp_q      <= '0;
         pend_q      <= 1'b0;
         pend_last_q <= 1'b0;
         pend_op_q   <= OpZeroPls;
         acc_q       <= '0;
         delta_q     <= '0;
         err_q       <= 1'b0;
      end else begin
         case (state_q)
            StIdle: begin
               if (opt_valid) begin
                  opt_q       <= opt;
                  cnt_q       <= '0;
                  tidx_q      <= '0;
                  pend_q      <= 1'b0;
                  pend_last_q <= 1'b0;
                  acc_q       <= '0;
                  if (!req_legal) begin
                     delta_q <= '0;
                     err_q   <= 1'b1;
                  end
               end
            end
            StFetch: begin
               cnt_q <= cnt_q + 3'd1;
               // Data returned now belongs to the address issued last cycle.
               case (cnt_q)
                  3'd1:    c_k_q  <= pos_data;
                  3'd2:    c_km_q <= pos_data;
                  3'd3:    c_kp_q <= pos_data;
                  3'd4:    c_l_q  <= pos_data;
                  3'd5:    c_lp_q <= pos_data;
                  default: ;
               endcase
            end
            StCalc: begin
               pend_q      <= issue;
               pend_op_q   <= mc_term.op;
               pend_last_q <= issue && mc_last;
               if (issue) tidx_q <= tidx_q + 3'd1;
               if (pend_q) acc_q <= acc_d;
               if (pend_q && pend_last_q) begin
                  delta_q <= acc_d;
                  err_q   <= 1'b0;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_delta_distance.sv
// Self-checking bench for delta_distance: tour RAM and distance ROM models
// (d(a,b) = 100*|a-b|), scoreboard of expected results, latency and address-trace checks.
module tb_delta_distance;
   import replica_pkg::*;

   logic           clk;
   logic           reset;
   logic           opt_valid;
   logic           opt_ready;
   opt_t           opt;
   logic [6:0]     pos_addr;
   logic [6:0]     pos_data;
   logic [6:0]     dist_a;
   logic [6:0]     dist_b;
   distance_data_t dist_data;
   logic           delta_valid;
   delta_data_t    delta;
   logic           opt_err;

   typedef struct {
      int d;
      int e;
      int lat;
   } exp_t;

   exp_t       sb[$];
   int         tour[30];
   logic [6:0] trace[16];
   int         cyc;
   int         acc_cyc;
   int         n_checks;
   int         n_errors;

   delta_distance #(.CITY_NUM(30)) dut (
      .clk         (clk),
      .reset       (reset),
      .opt_valid   (opt_valid),
      .opt_ready   (opt_ready),
      .opt         (opt),
      .pos_addr    (pos_addr),
      .pos_data    (pos_data),
      .dist_a      (dist_a),
      .dist_b      (dist_b),
      .dist_data   (dist_data),
      .delta_valid (delta_valid),
      .delta       (delta),
      .opt_err     (opt_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic int absdiff(input int a, input int b);
      return (a > b) ? a - b : b - a;
   endfunction

   // Memory models, both with one-cycle read latency.
   always @(posedge clk) begin
      pos_data  <= (pos_addr < 7'd30) ? 7'(tour[pos_addr]) : 7'd0;
      dist_data <= 18'(100 * absdiff(int'(dist_a), int'(dist_b)));
   end

   always @(posedge clk) begin
      if (opt_valid && opt_ready) acc_cyc <= cyc;
      cyc <= cyc + 1;
   end

   task automatic check(input string tag, input int got, input int exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
      end
   endtask

   function automatic int dd(input int a, input int b);
      return 100 * absdiff(tour[a], tour[b]);
   endfunction

   // Reference: spec formulas over tour positions.
   function automatic int model_delta(input opt_command_t c, input int k, input int l,
                                      output int err);
      int km, kp, lp;
      err = ((c == CmdThr) || (k >= 30) || (l >= 30) ||
             (((c == CmdTwo) || (c == CmdOr0)) && (k >= l)) ||
             ((c == CmdOr1) && (k <= l + 1))) ? 1 : 0;
      if (err != 0) return 0;
      km = (k + 29) % 30;
      kp = (k + 1) % 30;
      lp = (l + 1) % 30;
      if (c == CmdTwo) return dd(k, l) + dd(kp, lp) - dd(k, kp) - dd(l, lp);
      return dd(km, kp) + dd(l, k) + dd(k, lp) - dd(km, k) - dd(k, kp) - dd(l, lp);
   endfunction

   always @(negedge clk) begin
      exp_t e;
      if (!reset && delta_valid) begin
         if (sb.size() == 0) begin
            check("spurious_delta_valid", 1, 0);
         end else begin
            e = sb.pop_front();
            check("delta", int'(delta), e.d);
            check("opt_err", int'(opt_err), e.e);
            check("latency", cyc - acc_cyc, e.lat);
         end
      end
      if ((cyc - acc_cyc) >= 0 && (cyc - acc_cyc) < 16) trace[cyc - acc_cyc] = pos_addr;
   end

   task automatic send(input opt_command_t c, input int k, input int l, input int exp_d,
                       input int exp_e, input int exp_l, input bit push);
      int   guard;
      exp_t e;
      @(negedge clk);
      guard = 0;
      while (!opt_ready && guard < 50) begin
         @(negedge clk);
         guard++;
      end
      if (!opt_ready) check("ready_timeout", 0, 1);
      for (int i = 0; i < 16; i++) trace[i] = '0;
      opt.command = c;
      opt.k       = 7'(k);
      opt.l       = 7'(l);
      opt_valid   = 1'b1;
      if (push) begin
         e.d   = exp_d;
         e.e   = exp_e;
         e.lat = exp_l;
         sb.push_back(e);
      end
      @(negedge clk);
      opt_valid   = 1'b0;
      // Scramble the bus to show it is only sampled on acceptance.
      opt.command = opt_command_t'(2'($urandom));
      opt.k       = 7'($urandom);
      opt.l       = 7'($urandom);
   endtask

   task automatic wait_done();
      int guard;
      guard = 0;
      while (sb.size() != 0 && guard < 40) begin
         @(negedge clk);
         guard++;
      end
      if (sb.size() != 0) begin
         check("done_timeout", sb.size(), 0);
         sb.delete();
      end
   endtask

   task automatic send_model(input opt_command_t c, input int k, input int l);
      int d, e;
      d = model_delta(c, k, l, e);
      send(c, k, l, d, e, (e != 0) ? 1 : ((c == CmdTwo) ? 12 : 14), 1'b1);
      wait_done();
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      opt_command_t inv_cmd[4];
      int           inv_k[4];
      int           inv_l[4];
      int           guard, any, k, l, i, j, t;
      opt_command_t c;

      n_checks  = 0;
      n_errors  = 0;
      cyc       = 0;
      acc_cyc   = -1000;
      reset     = 1'b1;
      opt_valid = 1'b0;
      opt       = '0;
      for (int p = 0; p < 30; p++) tour[p] = p;
      for (int p = 0; p < 16; p++) trace[p] = '0;

      repeat (3) @(negedge clk);
      check("rst_delta_valid", int'(delta_valid), 0);
      check("rst_delta", int'(delta), 0);
      check("rst_opt_err", int'(opt_err), 0);
      check("rst_pos_addr", int'(pos_addr), 0);
      check("rst_dist_a", int'(dist_a), 0);
      check("rst_dist_b", int'(dist_b), 0);
      reset = 1'b0;
      @(negedge clk);
      check("rst_opt_ready", int'(opt_ready), 1);

      send(CmdTwo, 2, 5, 400, 0, 12, 1'b1);
      wait_done();
      send(CmdOr0, 3, 10, 1400, 0, 14, 1'b1);
      wait_done();
      send(CmdOr1, 29, 5, 4400, 0, 14, 1'b1);
      wait_done();
      check("or1_addr_c1", int'(trace[1]), 29);
      check("or1_addr_c2", int'(trace[2]), 28);
      check("or1_addr_c3", int'(trace[3]), 0);
      check("or1_addr_c4", int'(trace[4]), 5);
      check("or1_addr_c5", int'(trace[5]), 6);
      repeat (3) @(negedge clk);
      check("hold_delta", int'(delta), 4400);
      check("hold_opt_err", int'(opt_err), 0);

      tour[3] = 6; tour[4] = 5; tour[5] = 4; tour[6] = 3;
      send(CmdTwo, 2, 6, -600, 0, 12, 1'b1);
      wait_done();
      check("neg_delta_bits", int'({11'd0, delta}), 32'h1FFDA8);
      for (int p = 0; p < 30; p++) tour[p] = p;

      inv_cmd[0] = CmdThr; inv_k[0] = 1;  inv_l[0] = 5;
      inv_cmd[1] = CmdTwo; inv_k[1] = 5;  inv_l[1] = 5;
      inv_cmd[2] = CmdOr1; inv_k[2] = 6;  inv_l[2] = 5;
      inv_cmd[3] = CmdTwo; inv_k[3] = 30; inv_l[3] = 31;
      for (int n = 0; n < 4; n++) begin
         send(inv_cmd[n], inv_k[n], inv_l[n], 0, 1, 1, 1'b1);
         wait_done();
         repeat (6) @(negedge clk);
         any = 0;
         for (int p = 0; p < 8; p++) any = any | int'(trace[p]);
         check("invalid_no_pos_addr", any, 0);
      end

      // Abort a TWO request with reset in cycle 8.
      send(CmdTwo, 2, 5, 0, 0, 0, 1'b0);
      guard = 0;
      while ((cyc - acc_cyc) != 8 && guard < 20) begin
         @(negedge clk);
         guard++;
      end
      check("abort_reached_cycle8", cyc - acc_cyc, 8);
      reset = 1'b1;
      #1;
      check("abort_delta_valid", int'(delta_valid), 0);
      check("abort_delta", int'(delta), 0);
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      check("abort_opt_ready", int'(opt_ready), 1);
      repeat (10) @(negedge clk);
      send(CmdTwo, 2, 5, 400, 0, 12, 1'b1);
      wait_done();

      // Random legal moves on a shuffled tour.
      for (int s = 0; s < 12; s++) begin
         i = $urandom_range(0, 29);
         j = $urandom_range(0, 29);
         t = tour[i]; tour[i] = tour[j]; tour[j] = t;
      end
      for (int n = 0; n < 8; n++) begin
         c = opt_command_t'(2'($urandom_range(0, 2)));
         if (c == CmdOr1) begin
            l = $urandom_range(0, 27);
            k = $urandom_range(l + 2, 29);
         end else begin
            k = $urandom_range(0, 28);
            l = $urandom_range(k + 1, 29);
         end
         send_model(c, k, l);
      end

      repeat (3) @(negedge clk);
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule

// File: doc/delta_distance.md
# delta_distance

Computes the signed tour-length change for one proposed move (`opt_t`) on one replica. It reads city indices from the replica's tour-order RAM and pair distances from the distance ROM, then accumulates the terms. It sits directly upstream of the Metropolis accept/exchange stage, which consumes `delta` together with the replica's current `distance_data_t`.

## Interface
Parameters:
- `CITY_NUM`, default `replica_pkg::city_num` (30): tour length; positions are 0..CITY_NUM-1.

Ports:
- `clk`  in  1  clock.
- `reset`  in  1  asynchronous, active-high reset.
- `opt_valid`  in  1  move request valid.
- `opt_ready`  out  1  block idle; the request is accepted when `opt_valid && opt_ready`.
- `opt`  in  `opt_t`  command, K, L.
- `pos_addr`  out  7  tour-order RAM read address (position).
- `pos_data`  in  7  city index at `pos_addr`; 1-cycle read latency.
- `dist_a`, `dist_b`  out  7 each  distance ROM city pair.
- `dist_data`  in  `distance_data_t`  d(`dist_a`,`dist_b`); 1-cycle latency.
- `delta_valid`  out  1  single-cycle pulse; result valid.
- `delta`  out  `delta_data_t` (signed 21)  new minus old tour length.
- `opt_err`  out  1  qualifies `delta_valid`; set when the request was rejected as invalid.

## Operation
- Position aliases: KM=K-1, KP=K+1, LP=L+1, all modulo CITY_NUM. 0-1 wraps to CITY_NUM-1; CITY_NUM-1+1 wraps to 0.
- FSM states: IDLE, FETCH, CALC, DONE. `opt_ready` is high only in IDLE.
- FETCH: issue positions K, KM, KP, L, LP, one per cycle, and latch the returned cities cK, cKM, cKP, cL, cLP.
- CALC: issue one distance pair per cycle. Each term is a pair of `distance_select_t` endpoints plus a `distance_op_t`. The first term uses ZERO+PLS semantics (accumulator = d); later terms use PLS/MNS.
- TWO (K<L): +d(cK,cL) +d(cKP,cLP) -d(cK,cKP) -d(cL,cLP). This is 4 terms.
- OR0 (K<L) and OR1 (K>L+1), which move city K to between L and LP: +d(cKM,cKP) +d(cL,cK) +d(cK,cLP) -d(cKM,cK) -d(cK,cKP) -d(cL,cLP). This is 6 terms.
- Invalid requests:
  - Any of: THR, K≥CITY_NUM, L≥CITY_NUM, a TWO/OR0 with K≥L, or an OR1 with K≤L+1.
  - No memory reads are issued.
  - Go straight to DONE with delta=0 and opt_err=1.
- Arithmetic: 18-bit unsigned terms are zero-extended to 21-bit signed. The worst case, ±3·(2^18-1), fits, so no saturation is needed.
- DONE: `delta_valid`=1 for one cycle, then IDLE.
- `delta` and `opt_err` hold their values until the next DONE.

## Timing
- Acceptance occurs at cycle 0.
- FETCH: `pos_addr` is driven in cycles 1-5; data is captured in cycles 2-6.
- CALC: pairs are issued in cycles 7..6+n; accumulation happens in cycles 8..7+n.
- `delta_valid` fires at cycle 12 for TWO and cycle 14 for OR0/OR1. For invalid requests it fires at cycle 1.
- Earliest next acceptance is the cycle after DONE.
- `opt` is sampled only at acceptance; later changes are ignored.
- Reset values:
  - state = IDLE, `opt_ready`=1 once reset deasserts.
  - `delta_valid`, `delta`, `opt_err`, `pos_addr`, `dist_a`, `dist_b` all 0.
- Reset mid-operation aborts immediately. No `delta_valid` is produced, and the accumulator is cleared.

## Structure
- Add to `replica_pkg`:
  - `typedef logic signed [20:0] delta_data_t`.
  - `typedef struct packed {distance_select_t a, b; distance_op_t op;} delta_term_t`.
  - `function wrap_pos`, the modular ±1 helper.
- Sub-module `delta_microcode`: combinational ROM mapping (opt_command, term index) to `delta_term_t` and a last-term flag.

## Test plan
All scenarios use CITY_NUM=30 and the ROM model d(a,b)=100·|a-b|. The tour order is identity unless stated.
- TWO K=2,L=5 -> delta=+400, opt_err=0, `delta_valid` at cycle 12.
- OR0 K=3,L=10 -> delta=+1400, `delta_valid` at cycle 14.
- OR1 K=29,L=5 (KP wraps to 0) -> delta=+4400. Also check `pos_addr` sequence 29,28,0,5,6.
- Tour positions 3..6 hold cities 6,5,4,3; TWO K=2,L=6 -> delta=-600 (0x1FFDA8).
- THR, TWO K=5,L=5, and OR1 K=6,L=5 -> each gives delta=0, opt_err=1 at cycle 1, with no `pos_addr` activity.
- Assert `reset` at cycle 8 of a TWO request -> no `delta_valid` is produced, `opt_ready`=1 after release. A following TWO K=2,L=5 returns +400.
